// File: rtl/shift_seq_pkg.sv
// Shared definitions for the shift sequencer: mode codes, FSM states, mode width.
// SHIFT_SEQ_ROTATE_EN decides whether ROR/ROL count as shift modes.
package shift_seq_pkg;

  localparam int MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    MODE_NOP  = 3'd0,
    MODE_LOAD = 3'd1,
    MODE_SHR  = 3'd2,
    MODE_SHL  = 3'd3,
    MODE_ASR  = 3'd4,
    MODE_ROR  = 3'd5,
    MODE_ROL  = 3'd6,
    MODE_RSVD = 3'd7
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Modes that walk through SHIFT; rotates only when the rotate datapath exists.
  function automatic logic is_shift_mode(input mode_e mode);
    logic r;
    case (mode)
      MODE_SHR, MODE_SHL, MODE_ASR: r = 1'b1;
`ifdef SHIFT_SEQ_ROTATE_EN
      MODE_ROR, MODE_ROL:           r = 1'b1;
`endif
      default:                      r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/shift_step_dp.sv
// Combinational single-step datapath: next register value and outgoing bits.
// Rotate paths exist only when SHIFT_SEQ_ROTATE_EN is defined.
module shift_step_dp
  import shift_seq_pkg::*;
#(
  parameter int N = 8,
  parameter int S = 1
) (
  input  logic [N-1:0] q,
  input  mode_e        mode,
  input  logic [S-1:0] ser_in,
  output logic [N-1:0] q_next,
  output logic [S-1:0] ser_out
);

  // Next register value for one S-bit step.
  always_comb begin
    q_next = q;
    case (mode)
      MODE_SHR: q_next = {ser_in, q[N-1:S]};
      MODE_SHL: q_next = {q[N-S-1:0], ser_in};
      MODE_ASR: q_next = {{S{q[N-1]}}, q[N-1:S]};
`ifdef SHIFT_SEQ_ROTATE_EN
      MODE_ROR: q_next = {q[S-1:0], q[N-1:S]};
      MODE_ROL: q_next = {q[N-S-1:0], q[N-1:N-S]};
`endif
      default:  q_next = q;
    endcase
  end

  // Bits leaving the register: MSB end for left-moving modes, LSB end otherwise.
  always_comb begin
    ser_out = q[S-1:0];
    case (mode)
      MODE_SHL, MODE_ROL: ser_out = q[N-1:N-S];
      default:            ser_out = q[S-1:0];
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Command-driven universal shift register: LOAD or k-step shifts, then a done pulse.
// Define SHIFT_SEQ_ROTATE_EN to enable ROR/ROL; otherwise they execute as NOP.
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int N     = 8,
  parameter int S     = 1,
  parameter int CNT_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [MODE_W-1:0] cmd_mode,
  input  logic [CNT_W-1:0]  cmd_count,
  input  logic [N-1:0]      load_data,
  input  logic [S-1:0]      ser_in,
  output logic [S-1:0]      ser_out,
  output logic              ser_out_valid,
  output logic [N-1:0]      q,
  output logic              busy,
  output logic              done
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [N-1:0]     q_q, q_d;
  logic             idle_q, busy_q, done_q, sov_q;
  logic [N-1:0]     dp_q_next;
  logic [S-1:0]     dp_ser_out;
  mode_e            cmd_mode_s;

  assign cmd_mode_s = mode_e'(cmd_mode);

  shift_step_dp #(.N(N), .S(S)) u_dp (
    .q       (q_q),
    .mode    (mode_q),
    .ser_in  (ser_in),
    .q_next  (dp_q_next),
    .ser_out (dp_ser_out)
  );

  // Next-state logic: command handshake in IDLE, one step per SHIFT cycle.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    remaining_d = remaining_q;
    q_d         = q_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          mode_d      = cmd_mode_s;
          remaining_d = cmd_count;
          if (cmd_mode_s == MODE_LOAD) begin
            q_d     = load_data;
            state_d = ST_DONE;
          end else if (is_shift_mode(cmd_mode_s) && (cmd_count != '0)) begin
            state_d = ST_SHIFT;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        q_d         = dp_q_next;
        remaining_d = remaining_q - CNT_ONE;
        if (remaining_q == CNT_ONE) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, datapath and registered status outputs derived from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_NOP;
      remaining_q <= '0;
      q_q         <= '0;
      idle_q      <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      sov_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      remaining_q <= remaining_d;
      q_q         <= q_d;
      idle_q      <= (state_d == ST_IDLE);
      busy_q      <= (state_d != ST_IDLE);
      done_q      <= (state_d == ST_DONE);
      sov_q       <= (state_d == ST_SHIFT);
    end
  end

  // Ready is held low for as long as reset is asserted.
  assign cmd_ready     = idle_q & ~reset;
  assign ser_out       = sov_q ? dp_ser_out : '0;
  assign ser_out_valid = sov_q;
  assign q             = q_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed table-driven bench for shift_sequencer (N=8,S=1) plus an S=2 rotate check.
// Expectations follow SHIFT_SEQ_ROTATE_EN when it is defined.
module tb_shift_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid, cmd_ready;
  logic [2:0] cmd_mode;
  logic [3:0] cmd_count;
  logic [7:0] load_data;
  logic       ser_in, ser_out, ser_out_valid;
  logic [7:0] q;
  logic       busy, done;

  logic       c2_valid, r2_ready;
  logic [2:0] c2_mode;
  logic [3:0] c2_count;
  logic [7:0] c2_load;
  logic [1:0] c2_ser, r2_sout;
  logic       r2_sov, r2_busy, r2_done;
  logic [7:0] r2_q;

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  shift_sequencer #(.N(8), .S(1), .CNT_W(4)) u_dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_mode(cmd_mode), .cmd_count(cmd_count), .load_data(load_data),
    .ser_in(ser_in), .ser_out(ser_out), .ser_out_valid(ser_out_valid),
    .q(q), .busy(busy), .done(done)
  );

  shift_sequencer #(.N(8), .S(2), .CNT_W(4)) u_dut2 (
    .clk(clk), .reset(reset), .cmd_valid(c2_valid), .cmd_ready(r2_ready),
    .cmd_mode(c2_mode), .cmd_count(c2_count), .load_data(c2_load),
    .ser_in(c2_ser), .ser_out(r2_sout), .ser_out_valid(r2_sov),
    .q(r2_q), .busy(r2_busy), .done(r2_done)
  );

  typedef struct {
    logic [2:0]  mode;
    logic [3:0]  count;
    logic [7:0]  load;
    logic [15:0] ser;      // step i drives ser[15-i]
    logic [7:0]  exp_q;
    int          exp_done; // cycle of done pulse after handshake cycle 0
    int          exp_sov;  // number of ser_out_valid cycles
    logic [15:0] exp_sout; // step i ser_out lands in bit 15-i
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int          cyc_done;
    int          nsov;
    int          stepi;
    logic [15:0] sout;
    string       tag;
    tag = $sformatf("vec%0d", idx);
    @(negedge clk);
    chk({tag, "_ready_pre"}, {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_mode  = v.mode;
    cmd_count = v.count;
    load_data = v.load;
    ser_in    = 1'b0;
    @(negedge clk);
    cyc_done = 0;
    nsov     = 0;
    sout     = 16'h0000;
    for (int c = 1; c <= 40 && cyc_done == 0; c++) begin
      if (c == 1) chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
      stepi = nsov;
      if (ser_out_valid) begin
        if (nsov < 16) sout[15-nsov] = ser_out;
        nsov++;
        ser_in = v.ser[15-stepi];
      end else begin
        chk({tag, "_ser_out_idle"}, {31'd0, ser_out}, 32'd0);
        ser_in = 1'($urandom);
      end
      if (done) cyc_done = c;
      // cmd inputs are scrambled while the block is busy; they must be ignored
      cmd_valid = 1'($urandom);
      cmd_mode  = 3'($urandom);
      cmd_count = 4'($urandom);
      load_data = 8'($urandom);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    chk({tag, "_q"}, {24'd0, q}, {24'd0, v.exp_q});
    chk({tag, "_done_cycle"}, cyc_done, v.exp_done);
    chk({tag, "_sov_cycles"}, nsov, v.exp_sov);
    chk({tag, "_ser_out_seq"}, {16'd0, sout}, {16'd0, v.exp_sout});
    chk({tag, "_done_width"}, {31'd0, done}, 32'd0);
    chk({tag, "_ready_post"}, {31'd0, cmd_ready}, 32'd1);
  endtask

  initial begin
    vecs[0]  = '{3'd1, 4'd0,  8'hA5, 16'h0000, 8'hA5, 1,  0,  16'h0000};
    vecs[1]  = '{3'd2, 4'd8,  8'h00, 16'h0000, 8'h00, 9,  8,  16'hA500};
    vecs[2]  = '{3'd3, 4'd8,  8'h00, 16'hCB00, 8'hCB, 9,  8,  16'h0000};
    vecs[3]  = '{3'd1, 4'd0,  8'h80, 16'h0000, 8'h80, 1,  0,  16'h0000};
    vecs[4]  = '{3'd4, 4'd3,  8'h00, 16'hFFFF, 8'hF0, 4,  3,  16'h0000};
    vecs[5]  = '{3'd2, 4'd0,  8'h11, 16'hFFFF, 8'hF0, 1,  0,  16'h0000};
    vecs[6]  = '{3'd0, 4'd5,  8'h22, 16'h0000, 8'hF0, 1,  0,  16'h0000};
    vecs[7]  = '{3'd7, 4'd3,  8'h33, 16'h0000, 8'hF0, 1,  0,  16'h0000};
    vecs[8]  = '{3'd1, 4'd0,  8'h3C, 16'h0000, 8'h3C, 1,  0,  16'h0000};
`ifdef SHIFT_SEQ_ROTATE_EN
    vecs[9]  = '{3'd5, 4'd3,  8'h00, 16'hFFFF, 8'h87, 4,  3,  16'h2000};
    vecs[10] = '{3'd6, 4'd2,  8'h00, 16'h0000, 8'h1E, 3,  2,  16'h8000};
`else
    vecs[9]  = '{3'd5, 4'd3,  8'h00, 16'hFFFF, 8'h3C, 1,  0,  16'h0000};
    vecs[10] = '{3'd6, 4'd2,  8'h00, 16'h0000, 8'h3C, 1,  0,  16'h0000};
`endif
    vecs[11] = '{3'd1, 4'd0,  8'h3C, 16'h0000, 8'h3C, 1,  0,  16'h0000};
    vecs[12] = '{3'd3, 4'd10, 8'h00, 16'hFFC0, 8'hFF, 11, 10, 16'h3CC0};
    vecs[13] = '{3'd1, 4'd0,  8'h40, 16'h0000, 8'h40, 1,  0,  16'h0000};
    vecs[14] = '{3'd4, 4'd15, 8'h00, 16'hFFFF, 8'h00, 16, 15, 16'h0200};

    reset = 1'b1;
    cmd_valid = 1'b0; cmd_mode = 3'd0; cmd_count = 4'd0; load_data = 8'h00; ser_in = 1'b0;
    c2_valid = 1'b0; c2_mode = 3'd0; c2_count = 4'd0; c2_load = 8'h00; c2_ser = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_q", {24'd0, q}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_sov", {31'd0, ser_out_valid}, 32'd0);
    chk("rst_ser_out", {31'd0, ser_out}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready_after", {31'd0, cmd_ready}, 32'd1);

    for (int i = 0; i < 15; i++) run_vec(vecs[i], i);

    // Reset in cycle 3 of a count-8 SHR aborts the command without a done pulse.
    run_vec('{3'd1, 4'd0, 8'hA5, 16'h0000, 8'hA5, 1, 0, 16'h0000}, 15);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_mode = 3'd2; cmd_count = 4'd8; ser_in = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("abort_c1_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    chk("abort_c2_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    chk("abort_c3_q", {24'd0, q}, 32'h29);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_rst_q", {24'd0, q}, 32'd0);
    chk("abort_rst_done", {31'd0, done}, 32'd0);
    chk("abort_rst_ready", {31'd0, cmd_ready}, 32'd0);
    chk("abort_rst_sov", {31'd0, ser_out_valid}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_ready", {31'd0, cmd_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("abort_no_done", {31'd0, done}, 32'd0);
      chk("abort_q_zero", {24'd0, q}, 32'd0);
      @(negedge clk);
    end

    // S=2 instance: LOAD 0x81 then ROR count 1.
    chk("dut2_ready", {31'd0, r2_ready}, 32'd1);
    c2_valid = 1'b1; c2_mode = 3'd1; c2_load = 8'h81;
    @(negedge clk);
    c2_valid = 1'b0;
    chk("dut2_load_done", {31'd0, r2_done}, 32'd1);
    chk("dut2_load_q", {24'd0, r2_q}, 32'h81);
    @(negedge clk);
    chk("dut2_ready2", {31'd0, r2_ready}, 32'd1);
    c2_valid = 1'b1; c2_mode = 3'd5; c2_count = 4'd1; c2_ser = 2'b11;
    @(negedge clk);
    c2_valid = 1'b0;
`ifdef SHIFT_SEQ_ROTATE_EN
    chk("dut2_ror_sov", {31'd0, r2_sov}, 32'd1);
    chk("dut2_ror_sout", {30'd0, r2_sout}, 32'd1);
    chk("dut2_ror_nodone", {31'd0, r2_done}, 32'd0);
    @(negedge clk);
    chk("dut2_ror_done", {31'd0, r2_done}, 32'd1);
    chk("dut2_ror_q", {24'd0, r2_q}, 32'h60);
`else
    chk("dut2_ror_sov", {31'd0, r2_sov}, 32'd0);
    chk("dut2_ror_done", {31'd0, r2_done}, 32'd1);
    chk("dut2_ror_q", {24'd0, r2_q}, 32'h81);
`endif
    @(negedge clk);
    chk("dut2_ready3", {31'd0, r2_ready}, 32'd1);
    chk("dut2_done_low", {31'd0, r2_done}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
